exec_stage_pipe: RTL and testbench
==================================

// Module: exec_stage_pipe
// PURPOSE
//  Registered Y86-64 execute stage: computes valE for every icode, owns the condition-code
//  register (ZF,SF,OF), evaluates cnd for jXX/cmovXX, presents results through a one-entry
//  valid/ready output register to the memory stage. Sits between decode and memory.
// PARAMETERS
//  N        64   datapath width (valA/valB/valC/valE); must be >= 8
//  SP_STEP  8    stack-pointer step applied by call/pushq (sub) and ret/popq (add)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  in_valid   in   1   decode presents an instruction
//  in_ready   out  1   stage can accept this cycle
//  icode      in   4   Y86 icode
//  ifun       in   4   Y86 ifun (ALU op / condition)
//  valA       in   N   operand A
//  valB       in   N   operand B
//  valC       in   N   immediate / displacement
//  cc_hold    in   1   suppress CC update (later-stage exception in flight)
//  out_valid  out  1   result register holds a valid result
//  out_ready  in   1   memory stage consumes result
//  valE       out  N   registered ALU result
//  cnd        out  1   registered condition outcome
//  cc         out  3   {ZF,SF,OF} current CC register
//  out_err    out  1   registered illegal-op flag (icode 6 with unsupported ifun, or icode>11)
// BEHAVIOUR
//  - Reset: out_valid=0, valE=0, cnd=0, out_err=0, cc=3'b100 (ZF=1), mul FSM IDLE.
//  - in_ready = !busy && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  - Latency 1 cycle: accepted at edge k -> out_valid=1 after edge k. Output held stable
//    while out_valid && !out_ready. Simultaneous drain+accept gives full throughput.
//  - valE: 2 cmov/rrmov: valA | 3 irmov: valC | 4/5 rm/mrmov: valB+valC |
//    6 OPq: ifun 0 valB+valA, 1 valB-valA, 2 valB&valA, 3 valB^valA |
//    8 call, A push: valB-SP_STEP | 9 ret, B pop: valB+SP_STEP | others (0,1,7): 0.
//  - All arithmetic modulo 2^N; carries discarded.
//  - CC written at accept edge only for icode 6 with legal ifun and cc_hold=0.
//    ZF=(res==0); SF=res[N-1]; OF: add (A[N-1]==B[N-1])&&(res[N-1]!=B[N-1]);
//    sub (A[N-1]!=B[N-1])&&(res[N-1]!=B[N-1]); and/xor 0.
//  - cnd for icode 2/7 uses CC value before this instruction's edge (a preceding
//    OPq already committed): ifun 0 1, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne !ZF,
//    5 ge !(SF^OF), 6 g !(SF^OF)&!ZF, 7-15 0. Other icodes: cnd=1.
//  - Illegal op: out_err=1, valE=0, cnd=0, CC unchanged; still occupies one output slot.
//  - Reset mid-operation (incl. mid-multiply) discards the in-flight result; no output.
// CONFIGURATION
//  EXEC_MULQ_EN defined: icode 6 ifun 4 = mulq, valE = low N bits of valB*valA
//   (unsigned shift-add), FSM IDLE->MUL (N cycles, busy=1, in_ready=0)->DONE->IDLE;
//   result written to output register at end of MUL; out_valid N+1 cycles after accept.
//   CC: ZF/SF from low result, OF=1 iff any high-half product bit nonzero; honours cc_hold
//   as sampled at accept. Output-register backpressure delays DONE, not the FSM count.
//  Undefined: ifun 4 is illegal (out_err=1); no FSM, busy tied 0.
// TESTING
//  1 reset, then OPq add valA=1,valB=2 -> next cycle valE=3, out_valid=1, cc=000.
//  2 OPq sub A=B=5 then jXX ifun 3 -> sub: valE=0, cc=100; jXX: cnd=1; then ifun 4: cnd=0.
//  3 add A=B=0x7FFF_FFFF_FFFF_FFFF -> valE=0xFFFF_FFFF_FFFF_FFFE, cc=011; with cc_hold=1
//    cc stays unchanged.
//  4 call valB=0x100 with out_ready=0 for 3 cycles -> valE=0xF8 held stable, in_ready=0;
//    release -> next instr accepted same cycle.
//  5 EXEC_MULQ_EN: mulq A=3,B=7 -> in_ready=0 for N cycles, valE=21, cc=000; reset at
//    cycle 10 -> out_valid stays 0, cc=100. Without macro: out_err=1, valE=0.
//  6 icode 6 ifun 9 -> out_err=1, cc unchanged; irmov valC=0x42 -> valE=0x42, cnd=1.

Source files
------------

// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe: registered Y86-64 execute stage.
// Computes valE for every icode, owns the {ZF,SF,OF} condition-code register,
// evaluates cnd for jXX/cmovXX and hands results to the memory stage through a
// one-entry valid/ready output register.
// Optional feature macro: EXEC_MULQ_EN adds a multi-cycle unsigned shift-add
// mulq (icode 6, ifun 4). Without it, ifun 4 is reported as an illegal op.
module exec_stage_pipe #(
  parameter int N       = 64,
  parameter int SP_STEP = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [N-1:0] valA,
  input  logic [N-1:0] valB,
  input  logic [N-1:0] valC,
  input  logic         cc_hold,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] valE,
  output logic         cnd,
  output logic [2:0]   cc,
  output logic         out_err
);

  logic         outValid_q;
  logic [N-1:0] valE_q;
  logic         cnd_q;
  logic         err_q;
  logic [2:0]   cc_q;

  logic         accept;
  logic         acceptPlain;
  logic         busy;
  logic         isMul;
  logic         illegal;
  logic [N-1:0] aluRes;
  logic         ccWrite;
  logic [2:0]   ccNew;
  logic         cndNew;
  logic [N-1:0] addRes;
  logic [N-1:0] subRes;

  logic         mulFinish;
  logic [N-1:0] mulResult;
  logic [2:0]   mulCc;
  logic         mulCcEn;

  assign addRes = valB + valA;
  assign subRes = valB - valA;

  assign in_ready    = !busy && (!outValid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign acceptPlain = accept && !isMul;

  // Decode the icode/ifun into the ALU result, the illegal flag and the CC update
  always_comb begin
    aluRes  = '0;
    illegal = 1'b0;
    ccWrite = 1'b0;
    ccNew   = cc_q;
    isMul   = 1'b0;
    case (icode)
      4'd2: aluRes = valA;
      4'd3: aluRes = valC;
      4'd4, 4'd5: aluRes = valB + valC;
      4'd6: begin
        case (ifun)
          4'd0: begin
            aluRes  = addRes;
            ccWrite = !cc_hold;
            ccNew   = {addRes == '0, addRes[N-1],
                       (valA[N-1] == valB[N-1]) && (addRes[N-1] != valB[N-1])};
          end
          4'd1: begin
            aluRes  = subRes;
            ccWrite = !cc_hold;
            ccNew   = {subRes == '0, subRes[N-1],
                       (valA[N-1] != valB[N-1]) && (subRes[N-1] != valB[N-1])};
          end
          4'd2: begin
            aluRes  = valB & valA;
            ccWrite = !cc_hold;
            ccNew   = {(valB & valA) == '0, aluRes[N-1], 1'b0};
          end
          4'd3: begin
            aluRes  = valB ^ valA;
            ccWrite = !cc_hold;
            ccNew   = {(valB ^ valA) == '0, aluRes[N-1], 1'b0};
          end
`ifdef EXEC_MULQ_EN
          4'd4: isMul = 1'b1;
`endif
          default: illegal = 1'b1;
        endcase
      end
      4'd8, 4'd10: aluRes = valB - N'(SP_STEP);
      4'd9, 4'd11: aluRes = valB + N'(SP_STEP);
      4'd0, 4'd1, 4'd7: aluRes = '0;
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      aluRes  = '0;
      ccWrite = 1'b0;
    end
  end

  // Evaluate the branch/cmov condition against the CC value already committed
  always_comb begin
    cndNew = 1'b1;
    if (icode == 4'd2 || icode == 4'd7) begin
      case (ifun)
        4'd0: cndNew = 1'b1;
        4'd1: cndNew = (cc_q[1] ^ cc_q[0]) | cc_q[2];
        4'd2: cndNew = cc_q[1] ^ cc_q[0];
        4'd3: cndNew = cc_q[2];
        4'd4: cndNew = !cc_q[2];
        4'd5: cndNew = !(cc_q[1] ^ cc_q[0]);
        4'd6: cndNew = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
        default: cndNew = 1'b0;
      endcase
    end
    if (illegal) cndNew = 1'b0;
  end

`ifdef EXEC_MULQ_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} mulState_e;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mulState_e       state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2*N-1:0]  mcand_q;
  logic [N-1:0]    mplier_q;
  logic [2*N-1:0]  prod_q;
  logic            ccHold_q;

  // Multiplier FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Multiplier next-state: N shift-add steps, then wait for a free output slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && isMul) state_d = MUL;
      MUL:  if (cnt_q == CW'(N - 1)) state_d = DONE;
      DONE: if (!outValid_q || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiplier outputs: stall decode while active, publish the product from DONE
  always_comb begin
    busy      = (state_q != IDLE);
    mulFinish = (state_q == DONE) && (!outValid_q || out_ready);
    mulResult = prod_q[N-1:0];
    mulCc     = {prod_q[N-1:0] == '0, prod_q[N-1], |prod_q[2*N-1:N]};
    mulCcEn   = !ccHold_q;
  end

  // Shift-add datapath; cc_hold is captured at accept so a later change is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      ccHold_q <= 1'b0;
    end else if (accept && isMul) begin
      cnt_q    <= '0;
      mcand_q  <= {{N{1'b0}}, valA};
      mplier_q <= valB;
      prod_q   <= '0;
      ccHold_q <= cc_hold;
    end else if (state_q == MUL) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  assign busy      = 1'b0;
  assign mulFinish = 1'b0;
  assign mulResult = '0;
  assign mulCc     = 3'b000;
  assign mulCcEn   = 1'b0;
`endif

  // One-entry output register: load on accept or mul completion, drain on out_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q <= 1'b0;
      valE_q     <= '0;
      cnd_q      <= 1'b0;
      err_q      <= 1'b0;
    end else if (acceptPlain) begin
      outValid_q <= 1'b1;
      valE_q     <= aluRes;
      cnd_q      <= cndNew;
      err_q      <= illegal;
    end else if (mulFinish) begin
      outValid_q <= 1'b1;
      valE_q     <= mulResult;
      cnd_q      <= 1'b1;
      err_q      <= 1'b0;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  // Condition-code register, written only by legal OPq results not held off
  always_ff @(posedge clk) begin
    if (reset) begin
      cc_q <= 3'b100;
    end else if (acceptPlain && ccWrite) begin
      cc_q <= ccNew;
    end else if (mulFinish && mulCcEn) begin
      cc_q <= mulCc;
    end
  end

  assign out_valid = outValid_q;
  assign valE      = valE_q;
  assign cnd       = cnd_q;
  assign out_err   = err_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_exec_stage_pipe.sv
// tb_exec_stage_pipe: directed self-checking bench for exec_stage_pipe.
// Default build exercises the no-mulq configuration; with EXEC_MULQ_EN defined
// the multiply timing and mid-multiply reset are checked instead.
module tb_exec_stage_pipe;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [N-1:0] valA;
  logic [N-1:0] valB;
  logic [N-1:0] valC;
  logic         cc_hold;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] valE;
  logic         cnd;
  logic [2:0]   cc;
  logic         out_err;

  int checks   = 0;
  int failures = 0;

  exec_stage_pipe #(.N(N), .SP_STEP(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .cc_hold(cc_hold), .out_valid(out_valid), .out_ready(out_ready),
    .valE(valE), .cnd(cnd), .cc(cc), .out_err(out_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction for exactly one accept edge, then sample 1 time unit later
  task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    icode    = ic;
    ifun     = fn;
    valA     = a;
    valB     = b;
    valC     = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cc_hold = 1'b0;
    icode = 4'd0; ifun = 4'd0; valA = '0; valB = '0; valC = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_valE", valE, 0);
    checkOutput("rst_cnd", cnd, 0);
    checkOutput("rst_err", out_err, 0);
    checkOutput("rst_cc", cc, 3'b100);
    reset = 1'b0;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);

    applyStimulus(4'd6, 4'd0, 64'd1, 64'd2, 64'd0);
    checkOutput("add_valE", valE, 64'd3);
    checkOutput("add_valid", out_valid, 1);
    checkOutput("add_cc", cc, 3'b000);
    checkOutput("add_cnd", cnd, 1);

    applyStimulus(4'd6, 4'd1, 64'd5, 64'd5, 64'd0);
    checkOutput("sub_valE", valE, 64'd0);
    checkOutput("sub_cc", cc, 3'b100);
    applyStimulus(4'd7, 4'd3, 64'd0, 64'd0, 64'd0);
    checkOutput("je_cnd", cnd, 1);
    checkOutput("je_valE", valE, 64'd0);
    applyStimulus(4'd7, 4'd4, 64'd0, 64'd0, 64'd0);
    checkOutput("jne_cnd", cnd, 0);
    applyStimulus(4'd2, 4'd0, 64'h55, 64'd0, 64'd0);
    checkOutput("rrmov_valE", valE, 64'h55);
    checkOutput("rrmov_cnd", cnd, 1);

    applyStimulus(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    checkOutput("ovf_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("ovf_cc", cc, 3'b011);
    cc_hold = 1'b1;
    applyStimulus(4'd6, 4'd1, 64'd5, 64'd5, 64'd0);
    cc_hold = 1'b0;
    checkOutput("hold_valE", valE, 64'd0);
    checkOutput("hold_cc", cc, 3'b011);
    applyStimulus(4'd7, 4'd2, 64'd0, 64'd0, 64'd0);
    checkOutput("jl_ovf_cnd", cnd, 0);
    applyStimulus(4'd2, 4'd5, 64'h9, 64'd0, 64'd0);
    checkOutput("cmovge_cnd", cnd, 1);
    checkOutput("cmovge_valE", valE, 64'h9);

    applyStimulus(4'd8, 4'd0, 64'd0, 64'h100, 64'd0);
    checkOutput("call_valE", valE, 64'hF8);
    checkOutput("call_valid", out_valid, 1);
    out_ready = 1'b0;
    icode = 4'd3; ifun = 4'd0; valC = 64'h42; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput("bp_valE", valE, 64'hF8);
      checkOutput("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_next_valE", valE, 64'h42);
    checkOutput("bp_next_valid", out_valid, 1);

    applyStimulus(4'd9, 4'd0, 64'd0, 64'h100, 64'd0);
    checkOutput("ret_valE", valE, 64'h108);
    applyStimulus(4'd10, 4'd0, 64'd0, 64'h20, 64'd0);
    checkOutput("push_valE", valE, 64'h18);
    applyStimulus(4'd11, 4'd0, 64'd0, 64'h20, 64'd0);
    checkOutput("pop_valE", valE, 64'h28);
    applyStimulus(4'd4, 4'd0, 64'd0, 64'h10, 64'h8);
    checkOutput("rmmov_valE", valE, 64'h18);
    applyStimulus(4'd1, 4'd0, 64'd3, 64'd4, 64'd5);
    checkOutput("nop_valE", valE, 64'd0);

    applyStimulus(4'd6, 4'd2, 64'h3C, 64'hF0, 64'd0);
    checkOutput("and_valE", valE, 64'h30);
    checkOutput("and_cc", cc, 3'b000);
    applyStimulus(4'd6, 4'd3, 64'hAA, 64'hAA, 64'd0);
    checkOutput("xor_valE", valE, 64'd0);
    checkOutput("xor_cc", cc, 3'b100);
    applyStimulus(4'd6, 4'd1, 64'd1, 64'd0, 64'd0);
    checkOutput("neg_valE", valE, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("neg_cc", cc, 3'b010);
    applyStimulus(4'd7, 4'd2, 64'd0, 64'd0, 64'd0);
    checkOutput("jl_neg_cnd", cnd, 1);
    applyStimulus(4'd7, 4'd6, 64'd0, 64'd0, 64'd0);
    checkOutput("jg_neg_cnd", cnd, 0);
    applyStimulus(4'd7, 4'd9, 64'd0, 64'd0, 64'd0);
    checkOutput("jbad_cnd", cnd, 0);

    applyStimulus(4'd6, 4'd9, 64'd1, 64'd2, 64'd0);
    checkOutput("ill_err", out_err, 1);
    checkOutput("ill_valE", valE, 64'd0);
    checkOutput("ill_cnd", cnd, 0);
    checkOutput("ill_cc", cc, 3'b010);
    checkOutput("ill_valid", out_valid, 1);
    applyStimulus(4'd12, 4'd0, 64'd1, 64'd2, 64'd3);
    checkOutput("ill_icode_err", out_err, 1);
    applyStimulus(4'd3, 4'd0, 64'd0, 64'd0, 64'h42);
    checkOutput("irmov_valE", valE, 64'h42);
    checkOutput("irmov_cnd", cnd, 1);
    checkOutput("irmov_err", out_err, 0);

`ifdef EXEC_MULQ_EN
    begin
      int waited;
      int sawValid;
      applyStimulus(4'd6, 4'd4, 64'd3, 64'd7, 64'd0);
      checkOutput("mul_busy", in_ready, 0);
      waited = 0;
      while (!out_valid && waited < 200) begin
        @(posedge clk);
        #1;
        waited++;
      end
      checkOutput("mul_latency", waited, N + 1);
      checkOutput("mul_valE", valE, 64'd21);
      checkOutput("mul_cc", cc, 3'b000);
      checkOutput("mul_err", out_err, 0);
      applyStimulus(4'd6, 4'd4, 64'd3, 64'd7, 64'd0);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sawValid = 0;
      for (int i = 0; i < N + 4; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) sawValid = 1;
      end
      checkOutput("mul_rst_no_out", sawValid, 0);
      checkOutput("mul_rst_cc", cc, 3'b100);
      checkOutput("mul_rst_ready", in_ready, 1);
    end
`else
    applyStimulus(4'd6, 4'd4, 64'd3, 64'd7, 64'd0);
    checkOutput("nomul_err", out_err, 1);
    checkOutput("nomul_valE", valE, 64'd0);
    checkOutput("nomul_cc", cc, 3'b010);
    checkOutput("nomul_ready", in_ready, 1);
`endif

    icode = 4'd6; ifun = 4'd0; valA = 64'd1; valB = 64'd1; in_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_valE", valE, 64'd0);
    checkOutput("midrst_cc", cc, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
